// File: rtl/hex_display_reader.sv
// Recovers per-digit hex nibbles from a multiplexed active-low 7-segment bus.
// Optional frame tracking (frame_done / frame_count) is enabled by defining HEX_READER_FRAME_EN.
module hex_display_reader #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    update,
    output logic [2:0]              update_idx
`ifdef HEX_READER_FRAME_EN
    ,
    output logic                    frame_done,
    output logic [15:0]             frame_count
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic                    commit;
    logic                    same_sample;
    logic                    in_onehot;
    logic                    dec_valid;
    logic [3:0]              dec_nib;
    logic                    dec_blank;
    logic [2:0]              sel_idx;
    logic                    update_q;
    logic [2:0]              update_idx_q;
    logic [NUM_DIGITS-1:0][3:0] digit_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   err_q;

    assign in_onehot   = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
    assign same_sample = (seg_n == seg_q) && (dig_sel == sel_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q   <= '0;
            sel_q   <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            seg_q   <= seg_n;
            sel_q   <= dig_sel;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter counts samples as they are taken, so the commit edge is the
    // one that loads the STABLE_CYCLES-th identical sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_onehot) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            SETTLE: begin
                if (!in_onehot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same_sample) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q >= CNT_MAX - CNT_ONE) begin
                    state_d = HELD;
                    cnt_d   = CNT_MAX;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!same_sample) begin
                    if (in_onehot) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Inverse of the segment encoder table.
    always_comb begin
        dec_valid = 1'b1;
        dec_nib   = 4'h0;
        dec_blank = (seg_q == 7'h7F);
        case (seg_q)
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            default: dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                digit_q[gi] <= 4'h0;
                blank_q[gi] <= 1'b1;
                err_q[gi]   <= 1'b0;
            end else if (commit && sel_q[gi]) begin
                if (dec_valid) begin
                    digit_q[gi] <= dec_nib;
                    blank_q[gi] <= 1'b0;
                    err_q[gi]   <= 1'b0;
                end else if (dec_blank) begin
                    blank_q[gi] <= 1'b1;
                    err_q[gi]   <= 1'b0;
                end else begin
                    blank_q[gi] <= 1'b0;
                    err_q[gi]   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update_q     <= 1'b0;
            update_idx_q <= 3'd0;
        end else begin
            update_q <= commit;
            if (commit) begin
                update_idx_q <= sel_idx;
            end
        end
    end

    assign digits     = digit_q;
    assign blank      = blank_q;
    assign err        = err_q;
    assign update     = update_q;
    assign update_idx = update_idx_q;

`ifdef HEX_READER_FRAME_EN
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic                  frame_done_q, frame_done_d;
    logic [15:0]           frame_count_q, frame_count_d;

    // A frame completes on the commit that fills the last missing digit.
    always_comb begin
        seen_d        = seen_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        if (commit) begin
            seen_d = seen_q | sel_q;
            if (&seen_d) begin
                seen_d        = '0;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            seen_q        <= seen_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
`endif

endmodule
